// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the 8:1 TDM receive path
package tdm_pkg;
    localparam int N_CH = 8;
    localparam int SEL_W = $clog2(N_CH);
    typedef logic [SEL_W-1:0] slot_t;
    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;
endpackage

// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: serial link inputs and recovered parallel frame outputs
interface tdm_demux8_if;
    import tdm_pkg::*;
    logic en;
    logic din;
    logic sync;
    slot_t sel;
    logic [N_CH-1:0] slot_oh;
    logic [N_CH-1:0] dout;
    logic frame_valid;
    logic locked;
    logic sync_err;
    modport master(output en, din, sync, input sel, slot_oh, dout, frame_valid, locked, sync_err);
    modport slave(input en, din, sync, output sel, slot_oh, dout, frame_valid, locked, sync_err);
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: mod-N_CH slot counter with clear, load-to-1 on sync and step enable
module tdm_slot_ctr import tdm_pkg::*; (
    input  logic  clk,
    input  logic  clr,
    input  logic  en,
    input  logic  load,
    output slot_t sel,
    output logic  last
);
    always_ff @(posedge clk) begin
        if (clr) sel <= '0;
        else if (load) sel <= slot_t'(1);
        else if (en) sel <= sel + slot_t'(1);
    end
    assign last = sel == slot_t'(N_CH - 1);
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: steers serial TDM slots into channel registers and emits whole frames
module tdm_demux8 import tdm_pkg::*; (
    input logic clk,
    input logic reset,
    tdm_demux8_if.slave bus
);
    state_t state, state_nx;
    logic [N_CH-2:0] cap;
    slot_t sel, idx;
    logic last, strobe_lk, wr, done, misalign;
    assign strobe_lk = bus.en & (state == ST_LOCKED);
    assign wr = bus.en & (bus.sync | state == ST_LOCKED);
    assign done = strobe_lk & ~bus.sync & last;
    assign misalign = strobe_lk & bus.sync & (sel != '0);
    assign idx = bus.sync ? '0 : sel;
    tdm_slot_ctr u_ctr (
        .clk(clk),
        .clr(reset),
        .en(strobe_lk),
        .load(bus.en & bus.sync),
        .sel(sel),
        .last(last)
    );
    always_ff @(posedge clk) begin
        state <= reset ? ST_UNLOCKED : state_nx;
    end
    always_comb begin
        state_nx = (bus.en & bus.sync) ? ST_LOCKED : state;
    end
    always_comb begin
        bus.locked = state == ST_LOCKED;
    end
    assign bus.sel = sel;
    assign bus.slot_oh = {{(N_CH-1){1'b0}}, 1'b1} << sel;
    // The last slot bit bypasses cap and goes straight into dout with the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap <= '0;
            bus.dout <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err <= 1'b0;
        end else begin
            bus.frame_valid <= done;
            bus.sync_err <= misalign;
            for (int i = 0; i < N_CH - 1; i++)
                if (wr && idx == slot_t'(i)) cap[i] <= bus.din;
            if (done) bus.dout <= {bus.din, cap};
        end
    end
endmodule
